// File: rtl/icache_responder.sv
// Direct-mapped instruction cache that answers line requests from the fetch
// queue. Hits return in two cycles. Misses refill through a single-outstanding
// memory port. A redirect abort cancels the response, but a memory transfer
// that is already in flight is always allowed to finish and fill its line.
module icache_responder #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  input  logic         cache_rd_en,
  input  logic         cache_abort,
  output logic         ready,
  output logic [127:0] dout,
  output logic         dout_valid,
  output logic         mem_rd_en,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_data,
  input  logic         mem_valid
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_DRAIN
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  // Only the line address is kept; the byte offset is never used.
  logic [27:0]          r_req_line;
  logic [NUM_LINES-1:0] r_valid;
  logic [127:0]         r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_dout;
  logic                 r_dout_valid;

  logic [INDEX_W-1:0]   w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic                 w_accept;
  logic                 w_fill;
  logic                 w_respond;
  logic [127:0]         w_resp_data;
  logic                 w_unused_pc_offset;

  assign w_idx              = r_req_line[INDEX_W-1:0];
  assign w_tag              = r_req_line[27:INDEX_W];
  assign w_hit              = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_pc_offset = ^pc_in[3:0];

  assign ready      = (r_state == S_IDLE);
  assign mem_rd_en  = (r_state == S_MISS_REQ) && !cache_abort;
  assign mem_addr   = {r_req_line, 4'b0000};
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  // Next-state, request acceptance, fill and response decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_fill       = 1'b0;
    w_respond    = 1'b0;
    w_resp_data  = mem_data;
    case (r_state)
      S_IDLE: begin
        if (cache_rd_en && !cache_abort) begin
          w_accept     = 1'b1;
          w_next_state = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cache_abort) begin
          w_next_state = S_IDLE;
        end else if (w_hit) begin
          w_respond    = 1'b1;
          w_resp_data  = r_data[w_idx];
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        w_next_state = cache_abort ? S_IDLE : S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (mem_valid) begin
          w_fill       = 1'b1;
          w_respond    = !cache_abort;
          w_next_state = S_IDLE;
        end else if (cache_abort) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_valid) begin
          w_fill       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control state, request address, valid bits and the registered response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_line   <= '0;
      r_valid      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_dout_valid <= w_respond;
      if (w_accept) r_req_line <= pc_in[31:4];
      if (w_fill) r_valid[w_idx] <= 1'b1;
      if (w_respond) r_dout <= w_resp_data;
    end
  end

  // Data and tag storage written on every line fill.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are not reset; the cleared valid bits already mark every line empty.
    if (!rst && w_fill) begin
      r_data[w_idx] <= mem_data;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder. Stimulus pushes the expected line
// responses and refill addresses into queues. A monitor running on the falling
// edge pops and compares them whenever dout_valid or mem_rd_en is seen.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  pc_in = '0;
  logic         cache_rd_en = 1'b0;
  logic         cache_abort = 1'b0;
  logic         ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data = '0;
  logic         mem_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_dout_q [$];
  logic [31:0]  exp_mem_q  [$];
  logic         prev_dv = 1'b0;

  localparam logic [127:0] L0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] L1 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] L2 = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] L3 = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] L4 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] L5 = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
  localparam logic [127:0] L6 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [127:0] L7 = 128'h77777777_66666666_55555555_44444444;

  icache_responder #(.NUM_LINES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .cache_rd_en (cache_rd_en),
    .cache_abort (cache_abort),
    .ready       (ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every response and refill request.
  always @(negedge clk) begin
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (dout_valid) begin
        check("dout_valid_not_back_to_back", {127'd0, prev_dv}, 128'd0);
        if (exp_dout_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dout_valid: got dout=%h expected no response", dout);
        end else begin
          check("dout", dout, exp_dout_q.pop_front());
        end
      end
      if (mem_rd_en) begin
        if (exp_mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_rd_en: got addr=%h expected no request", mem_addr);
        end else begin
          check("mem_addr", {96'd0, mem_addr}, {96'd0, exp_mem_q.pop_front()});
        end
      end
      prev_dv = dout_valid;
    end
  end

  // Advance one cycle; inputs change and direct samples are taken 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] pc);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("ready_before_request", {127'd0, got}, 128'd1);
    pc_in       = pc;
    cache_rd_en = 1'b1;
    tick();
    cache_rd_en = 1'b0;
  endtask

  // Returns in the cycle where mem_rd_en is high (the MISS_REQ cycle).
  task automatic wait_mem_req();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("mem_req_seen", {127'd0, got}, 128'd1);
  endtask

  // Called in the MISS_REQ cycle; mem_valid arrives extra+1 cycles later.
  task automatic serve(input logic [127:0] data, input int extra);
    tick();
    repeat (extra) tick();
    mem_data  = data;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] line;

    // Reset state
    repeat (3) tick();
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_dout_valid", {127'd0, dout_valid}, 128'd0);
    check("rst_mem_rd_en", {127'd0, mem_rd_en}, 128'd0);
    check("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
    check("rst_dout", dout, 128'd0);
    rst = 1'b0;
    tick();

    // Cold miss at 0x1000, refill returned three cycles after the request
    exp_mem_q.push_back(32'h0000_1000);
    exp_dout_q.push_back(L0);
    request(32'h0000_1000);
    wait_mem_req();
    serve(L0, 2);
    check("miss_dout_valid", {127'd0, dout_valid}, 128'd1);
    check("miss_ready_after", {127'd0, ready}, 128'd1);
    tick();
    check("miss_pulse_ends", {127'd0, dout_valid}, 128'd0);
    check("dout_holds", dout, L0);

    // Hit at 0x1008: dout_valid two cycles after acceptance, no refill
    exp_dout_q.push_back(L0);
    request(32'h0000_1008);
    check("hit_not_early", {127'd0, dout_valid}, 128'd0);
    check("hit_ready_low", {127'd0, ready}, 128'd0);
    tick();
    check("hit_dout_valid", {127'd0, dout_valid}, 128'd1);
    line = dout;
    check("hit_word2", {96'd0, line[95:64]}, {96'd0, 32'h2222_2222});
    // Back-to-back hit accepted in the response cycle
    check("b2b_ready", {127'd0, ready}, 128'd1);
    exp_dout_q.push_back(L0);
    request(32'h0000_1004);
    tick();
    check("b2b_dout_valid", {127'd0, dout_valid}, 128'd1);
    tick();

    // Conflict on index 0: 0x1100 evicts 0x1000, which then misses again
    exp_mem_q.push_back(32'h0000_1100);
    exp_dout_q.push_back(L1);
    request(32'h0000_1100);
    wait_mem_req();
    serve(L1, 0);
    check("conflict_dout_valid", {127'd0, dout_valid}, 128'd1);
    exp_mem_q.push_back(32'h0000_1000);
    exp_dout_q.push_back(L2);
    request(32'h0000_1000);
    wait_mem_req();
    serve(L2, 1);
    check("remiss_dout_valid", {127'd0, dout_valid}, 128'd1);
    tick();

    // Abort in MISS_WAIT at 0x2000: drain the transfer, fill silently
    exp_mem_q.push_back(32'h0000_2000);
    request(32'h0000_2000);
    wait_mem_req();
    tick();
    cache_abort = 1'b1;
    tick();
    cache_abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_ready_low", {127'd0, ready}, 128'd0);
      tick();
    end
    mem_data  = L3;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    check("drain_no_dout_valid", {127'd0, dout_valid}, 128'd0);
    check("drain_ready_back", {127'd0, ready}, 128'd1);
    exp_dout_q.push_back(L3);
    request(32'h0000_2000);
    tick();
    check("drained_line_hits", {127'd0, dout_valid}, 128'd1);
    tick();

    // Abort in LOOKUP
    request(32'h0000_3000);
    cache_abort = 1'b1;
    tick();
    cache_abort = 1'b0;
    check("lookup_abort_ready", {127'd0, ready}, 128'd1);
    // Abort in the same cycle as the request
    pc_in       = 32'h0000_3000;
    cache_rd_en = 1'b1;
    cache_abort = 1'b1;
    tick();
    cache_rd_en = 1'b0;
    cache_abort = 1'b0;
    check("same_cycle_abort_ready", {127'd0, ready}, 128'd1);
    // Abort in MISS_REQ suppresses the memory request
    request(32'h0000_3000);
    tick();
    cache_abort = 1'b1;
    tick();
    cache_abort = 1'b0;
    check("missreq_abort_ready", {127'd0, ready}, 128'd1);
    repeat (4) tick();

    // cache_rd_en while busy is dropped, not queued
    exp_mem_q.push_back(32'h0000_5000);
    exp_dout_q.push_back(L4);
    request(32'h0000_5000);
    wait_mem_req();
    tick();
    pc_in       = 32'h0000_4000;
    cache_rd_en = 1'b1;
    tick();
    tick();
    cache_rd_en = 1'b0;
    mem_data  = L4;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    check("busy_req_dout_valid", {127'd0, dout_valid}, 128'd1);
    repeat (5) tick();
    check("busy_req_not_taken", {127'd0, ready}, 128'd1);

    // Reset during MISS_WAIT; the late mem_valid must be ignored
    exp_mem_q.push_back(32'h0000_6000);
    request(32'h0000_6000);
    wait_mem_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {127'd0, ready}, 128'd1);
    check("midrst_dout_valid", {127'd0, dout_valid}, 128'd0);
    mem_data  = L5;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    check("late_mem_valid_ignored", {127'd0, dout_valid}, 128'd0);
    check("late_mem_valid_ready", {127'd0, ready}, 128'd1);
    exp_mem_q.push_back(32'h0000_6000);
    exp_dout_q.push_back(L6);
    request(32'h0000_6000);
    wait_mem_req();
    serve(L6, 0);
    check("post_rst_miss", {127'd0, dout_valid}, 128'd1);
    exp_mem_q.push_back(32'h0000_1000);
    exp_dout_q.push_back(L7);
    request(32'h0000_1000);
    wait_mem_req();
    serve(L7, 0);
    check("post_rst_valid_cleared", {127'd0, dout_valid}, 128'd1);
    repeat (3) tick();

    check("dout_queue_drained", 128'(exp_dout_q.size()), 128'd0);
    check("mem_queue_drained", 128'(exp_mem_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
